// File: rtl/reg_file_sb.sv
// Integer register file with combinational read ports, one write port, optional
// write-to-read bypass, a per-register busy scoreboard and a post-reset clear sequencer.
module reg_file_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREG)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   ready_o,
   input  logic [NUM_RD*AW-1:0]   rs_addr_i,
   output logic [NUM_RD*XLEN-1:0] rs_data_o,
   output logic [NUM_RD-1:0]      rs_busy_o,
   input  logic                   RegWrite_i,
   input  logic [AW-1:0]          rd_addr_i,
   input  logic [XLEN-1:0]        rd_data_i,
   input  logic                   issue_i,
   input  logic [AW-1:0]          issue_addr_i
);

   typedef enum logic {INIT, RUN} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_clr_cnt;
   logic            r_ready;
   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;

   logic            w_wr_zero;

   assign ready_o   = r_ready;
   assign w_wr_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= INIT;
         r_clr_cnt <= '0;
         r_ready   <= 1'b0;
         r_busy    <= '0;
      end else begin
         case (r_state)
            INIT: begin
               // One entry cleared per edge; inputs are ignored until the sweep ends.
               r_regs[r_clr_cnt] <= '0;
               r_clr_cnt         <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == AW'(NREG - 1)) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
               end
            end
            RUN: begin
               if (RegWrite_i && !w_wr_zero)
                  r_regs[rd_addr_i] <= rd_data_i;
               for (int unsigned i = 0; i < NREG; i++) begin
                  if ((ZERO_REG != 0) && (i == 0))
                     r_busy[i] <= 1'b0;
                  else if (issue_i && (issue_addr_i == AW'(i)))
                     r_busy[i] <= 1'b1;
                  else if (RegWrite_i && (rd_addr_i == AW'(i)))
                     r_busy[i] <= 1'b0;
               end
            end
            default: r_state <= INIT;
         endcase
      end
   end

   always_comb begin
      logic [AW-1:0] w_addr;
      logic          w_byp;
      rs_data_o = '0;
      rs_busy_o = '0;
      w_addr    = '0;
      w_byp     = 1'b0;
      for (int unsigned p = 0; p < NUM_RD; p++) begin
         w_addr = rs_addr_i[p*AW +: AW];
         w_byp  = (BYPASS != 0) && RegWrite_i && (rd_addr_i == w_addr);
         if (r_ready) begin
            if ((ZERO_REG != 0) && (w_addr == '0))
               rs_data_o[p*XLEN +: XLEN] = '0;
            else if (w_byp)
               rs_data_o[p*XLEN +: XLEN] = rd_data_i;
            else
               rs_data_o[p*XLEN +: XLEN] = r_regs[w_addr];
            rs_busy_o[p] = r_busy[w_addr] && !w_byp;
         end
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected outputs, a negedge
// monitor pops and compares them against a bypassing 4-port and a non-bypassing 1-port instance.
module tb_reg_file_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready, nb_ready;
  logic [19:0]  rs_addr;
  logic [127:0] rs_data;
  logic [3:0]   rs_busy;
  logic [31:0]  nb_data;
  logic [0:0]   nb_busy;
  logic         we;
  logic [4:0]   rd_addr;
  logic [31:0]  rd_data;
  logic         iss_en;
  logic [4:0]   iss_addr;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(32), .NUM_RD(4), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready), .rs_addr_i(rs_addr),
    .rs_data_o(rs_data), .rs_busy_o(rs_busy), .RegWrite_i(we), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .issue_i(iss_en), .issue_addr_i(iss_addr));

  reg_file_sb #(.XLEN(32), .NREG(32), .NUM_RD(1), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk_i(clk), .rst_i(rst), .ready_o(nb_ready), .rs_addr_i(rs_addr[4:0]),
    .rs_data_o(nb_data), .rs_busy_o(nb_busy), .RegWrite_i(we), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .issue_i(iss_en), .issue_addr_i(iss_addr));

  // kinds: 0 ready, 1 data[p], 2 busy[p], 3 nb ready, 4 nb data, 5 nb busy
  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] get_act(int kind, int port);
    case (kind)
      0: return {31'b0, ready};
      1: return rs_data[port*32 +: 32];
      2: return {31'b0, rs_busy[port]};
      3: return {31'b0, nb_ready};
      4: return nb_data;
      default: return {31'b0, nb_busy[0]};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = q.pop_front();
      act = get_act(e.kind, e.port);
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input string n, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = kind; e.port = port; e.exp = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; rd_addr = '0; rd_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd_addr = a; rd_data = d;
  endtask

  task automatic iss(input logic [4:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] a3);
    rs_addr = {a3, a2, a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; idle(); set_rs(1, 2, 3, 4);
    cyc();
    rst = 1'b0;
    chk("rst_ready", 0, 0, 0);
    chk("rst_nb_ready", 3, 0, 0);
    for (int unsigned p = 0; p < 4; p++) begin
      chk("init_data", 1, p, 0);
      chk("init_busy", 2, p, 0);
    end
    for (int unsigned k = 1; k <= 32; k++) begin
      cyc();
      if (k == 10) begin
        wr(3, 32'hFF); iss(3); set_rs(3, 3, 3, 3);
        chk("init_nobypass", 1, 0, 0);
        chk("init_nobusy", 2, 0, 0);
      end else begin
        idle();
      end
      chk($sformatf("ready_edge%0d", k), 0, 0, (k == 32) ? 32'd1 : 32'd0);
    end
    tests++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL direct_ready: got %b expected 1", ready);
    end
    tests++;
    if (nb_ready !== 1'b1) begin
      fails++;
      $display("FAIL direct_nb_ready: got %b expected 1", nb_ready);
    end
    for (int unsigned b = 0; b < 8; b++) begin
      set_rs(5'(4*b), 5'(4*b+1), 5'(4*b+2), 5'(4*b+3));
      for (int unsigned p = 0; p < 4; p++) begin
        chk($sformatf("clear_x%0d", 4*b+p), 1, p, 0);
        chk($sformatf("clear_busy_x%0d", 4*b+p), 2, p, 0);
      end
      cyc();
    end

    wr(5, 32'hDEADBEEF); set_rs(5, 0, 0, 0);
    chk("x5_bypass", 1, 0, 32'hDEADBEEF);
    chk("x5_nb_old", 4, 0, 0);
    #1;
    tests++;
    if (rs_data[31:0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL direct_x5_bypass: got %h expected deadbeef", rs_data[31:0]);
    end
    tests++;
    if (nb_data !== 32'h0) begin
      fails++;
      $display("FAIL direct_x5_nb_old: got %h expected 00000000", nb_data);
    end
    cyc();
    idle();
    chk("x5_next", 1, 0, 32'hDEADBEEF);
    chk("x5_nb_next", 4, 0, 32'hDEADBEEF);
    cyc();

    wr(0, 32'h1234); iss(0); set_rs(0, 0, 0, 0);
    for (int unsigned p = 0; p < 4; p++) chk("x0_write_cyc", 1, p, 0);
    chk("x0_busy_cyc", 2, 0, 0);
    cyc();
    idle();
    chk("x0_after", 1, 0, 0);
    chk("x0_busy_after", 2, 0, 0);
    cyc();

    iss(7); set_rs(7, 7, 5, 0);
    chk("x7_issue_cyc", 2, 1, 0);
    cyc();
    idle();
    chk("x7_busy", 2, 1, 1);
    chk("x7_busy_p0", 2, 0, 1);
    chk("x7_nb_busy", 5, 0, 1);
    cyc();
    wr(7, 32'h55);
    chk("x7_wr_busy_byp", 2, 1, 0);
    chk("x7_wr_data_byp", 1, 1, 32'h55);
    chk("x7_wr_nb_busy", 5, 0, 1);
    chk("x7_wr_nb_old", 4, 0, 0);
    cyc();
    idle();
    chk("x7_cleared", 2, 1, 0);
    chk("x7_data", 1, 1, 32'h55);
    chk("x7_nb_data", 4, 0, 32'h55);
    chk("x7_nb_cleared", 5, 0, 0);
    chk("x5_untouched", 1, 2, 32'hDEADBEEF);
    cyc();
    iss(7);
    cyc();
    wr(7, 32'h66); iss(7);
    chk("x7_coll_busy_byp", 2, 1, 0);
    chk("x7_coll_data", 1, 1, 32'h66);
    chk("x7_coll_nb_busy", 5, 0, 1);
    cyc();
    idle();
    chk("x7_coll_busy_kept", 2, 1, 1);
    chk("x7_coll_data_next", 1, 1, 32'h66);
    #1;
    tests++;
    if (rs_busy[1] !== 1'b1) begin
      fails++;
      $display("FAIL direct_x7_coll_busy: got %b expected 1", rs_busy[1]);
    end
    cyc();

    wr(9, 32'hA5A5A5A5); set_rs(9, 9, 9, 9);
    for (int unsigned p = 0; p < 4; p++) chk("x9_alias_byp", 1, p, 32'hA5A5A5A5);
    cyc();
    idle();
    for (int unsigned p = 0; p < 4; p++) chk("x9_alias", 1, p, 32'hA5A5A5A5);
    cyc();

    rst = 1'b1; set_rs(7, 5, 9, 0);
    cyc();
    rst = 1'b0;
    chk("runrst_ready", 0, 0, 0);
    chk("runrst_data", 1, 0, 0);
    chk("runrst_busy", 2, 0, 0);
    for (int unsigned k = 1; k <= 10; k++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_ready", 0, 0, 0);
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL direct_midrst_ready: got %b expected 0", ready);
    end
    for (int unsigned k = 1; k <= 32; k++) begin
      cyc();
      chk($sformatf("midrst_ready_edge%0d", k), 0, 0, (k == 32) ? 32'd1 : 32'd0);
      chk($sformatf("midrst_nb_ready_edge%0d", k), 3, 0, (k == 32) ? 32'd1 : 32'd0);
    end
    set_rs(7, 5, 9, 3);
    for (int unsigned p = 0; p < 4; p++) chk("reinit_data", 1, p, 0);
    chk("reinit_x7_busy", 2, 0, 0);
    cyc();

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
